aes256_round_key_cache: RTL and testbench

// Downstream consumer of the AES-256 key schedule. Sequences round_count 0..NR-1

---
 rtl/aes256_round_key_cache.sv | 175 +++++++++++++++++
 tb/tb_aes256_round_key_cache.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_round_key_cache.sv
// aes256_round_key_cache
// Drives the AES-256 key schedule through rounds 0..NR-1 once per key load,
// captures every round key into a local store, then serves single-cycle
// registered random-access reads of those keys to the cipher round datapath.

module aes256_round_key_cache #(
    parameter int NR      = 15,
    parameter int KW      = 128,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_g,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          flush_i,
    output logic          ks_en_o,
    output logic [3:0]    ks_round_count_o,
    input  logic          ks_ready_i,
    input  logic [KW-1:0] ks_key_i,
    input  logic [3:0]    rd_idx_i,
    output logic [KW-1:0] rd_key_o,
    output logic          rd_valid_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    // Timeout counter only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic [TW-1:0]   tmo_r;
    logic [KW-1:0]   store_r [NR];
    logic            store_we_s;
    logic            rd_in_range_s;
    logic            last_round_s;
    logic            tmo_expired_s;

    // The key captured in CAPT is the one the schedule presents the cycle
    // after its ready pulse; an abort in the same cycle discards it.
    assign store_we_s    = (state_r == CAPT) && !flush_i;
    assign rd_in_range_s = ({1'b0, rd_idx_i} < 5'(NR));
    assign last_round_s  = (cnt_r == 4'(NR - 1));
    assign tmo_expired_s = (tmo_r == TW'(TIMEOUT - 1));

    // Expansion sequencer: state, round/timeout counters and all status outputs.
    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            cnt_r            <= 4'd0;
            tmo_r            <= {TW{1'b0}};
            ks_en_o          <= 1'b0;
            ks_round_count_o <= 4'd0;
            valid_o          <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_o <= 1'b0;
                    if (flush_i) begin
                        // Flush beats a simultaneous start: stay idle, drop keys.
                        valid_o <= 1'b0;
                        err_o   <= 1'b0;
                    end else if (start_i) begin
                        state_r          <= RUN;
                        cnt_r            <= 4'd0;
                        tmo_r            <= {TW{1'b0}};
                        valid_o          <= 1'b0;
                        err_o            <= 1'b0;
                        ks_en_o          <= 1'b1;
                        ks_round_count_o <= 4'd0;
                        busy_o           <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state_r <= IDLE;
                        ks_en_o <= 1'b0;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b0;
                        err_o   <= 1'b0;
                        tmo_r   <= {TW{1'b0}};
                    end else if (ks_ready_i) begin
                        state_r <= CAPT;
                        tmo_r   <= tmo_r + TW'(1);
                    end else if (tmo_expired_s) begin
                        // Schedule stalled: give up, leave the store invalid.
                        state_r <= IDLE;
                        err_o   <= 1'b1;
                        ks_en_o <= 1'b0;
                        busy_o  <= 1'b0;
                        tmo_r   <= {TW{1'b0}};
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                CAPT: begin
                    if (flush_i) begin
                        state_r <= IDLE;
                        ks_en_o <= 1'b0;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b0;
                        err_o   <= 1'b0;
                        tmo_r   <= {TW{1'b0}};
                    end else if (last_round_s) begin
                        state_r <= DONE;
                        ks_en_o <= 1'b0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        valid_o <= 1'b1;
                    end else begin
                        // Round index only moves here, on entry to RUN, so the
                        // schedule never sees it change mid-round.
                        state_r          <= RUN;
                        cnt_r            <= cnt_r + 4'd1;
                        tmo_r            <= {TW{1'b0}};
                        ks_round_count_o <= cnt_r + 4'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_o  <= 1'b0;
                    ks_en_o <= 1'b0;
                    if (flush_i) begin
                        valid_o <= 1'b0;
                        err_o   <= 1'b0;
                    end else begin
                        valid_o <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ks_en_o <= 1'b0;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

    // Round-key store: plain RAM-style array, intentionally not reset.
    always_ff @(posedge clk_g) begin
        if (store_we_s) begin
            store_r[cnt_r] <= ks_key_i;
        end
    end

    // Read port: registered lookup every cycle; out-of-range reads return zero.
    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            rd_key_o   <= {KW{1'b0}};
            rd_valid_o <= 1'b0;
        end else if (rd_in_range_s) begin
            rd_key_o   <= store_r[rd_idx_i];
            rd_valid_o <= valid_o;
        end else begin
            rd_key_o   <= {KW{1'b0}};
            rd_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes256_round_key_cache.sv
// Directed bench for aes256_round_key_cache: a behavioural AES-256 key
// schedule responder built from the FIPS-197 expansion, table-driven read
// sweeps, and hand sequences for timeout, flush, mid-run start and reset.

module tb_aes256_round_key_cache;

    logic          clk_g = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic          flush_i;
    logic          ks_en_o;
    logic [3:0]    ks_round_count_o;
    logic          ks_ready_i = 1'b0;
    logic [127:0]  ks_key_i = 128'd0;
    logic [3:0]    rd_idx_i;
    logic [127:0]  rd_key_o;
    logic          rd_valid_o;
    logic          valid_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [127:0] rk [16];
    logic [3:0]   stall_round = 4'd15;
    int           resp_wait = 0;
    bit           resp_phase = 1'b0;
    logic [3:0]   rlog [$];
    int           done_cnt = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         vld;
    } rd_vec_t;
    rd_vec_t tbl [16];

    aes256_round_key_cache dut (
        .clk_g            (clk_g),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .flush_i          (flush_i),
        .ks_en_o          (ks_en_o),
        .ks_round_count_o (ks_round_count_o),
        .ks_ready_i       (ks_ready_i),
        .ks_key_i         (ks_key_i),
        .rd_idx_i         (rd_idx_i),
        .rd_key_o         (rd_key_o),
        .rd_valid_o       (rd_valid_o),
        .valid_o          (valid_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    always #5 clk_g = ~clk_g;

    // ---------------- AES-256 key expansion model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            for (int b = 1; b < 256; b++) begin
                if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic build_model();
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) begin
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        end
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk[15] = 128'd0;
    endtask

    // Key schedule responder: ready after a round-dependent delay, key the next cycle.
    always @(negedge clk_g) begin
        ks_ready_i = 1'b0;
        if (resp_phase) begin
            ks_key_i   = rk[ks_round_count_o];
            resp_phase = 1'b0;
            resp_wait  = 0;
        end else begin
            ks_key_i = {4{32'hdeadbeef}};
            if (!ks_en_o || !rst_n) begin
                resp_wait = 0;
            end else if (ks_round_count_o != stall_round) begin
                resp_wait++;
                if (resp_wait >= 1 + (int'(ks_round_count_o) % 3)) begin
                    ks_ready_i = 1'b1;
                    resp_phase = 1'b1;
                    rlog.push_back(ks_round_count_o);
                end
            end
        end
    end

    // Count done pulses as seen away from the active edge.
    always @(negedge clk_g) begin
        if (done_o) done_cnt++;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ks_en"}, ks_en_o, 1'b0);
        chk({tag, "_round_count"}, ks_round_count_o, 4'd0);
        chk({tag, "_rd_key"}, rd_key_o, 128'd0);
        chk({tag, "_rd_valid"}, rd_valid_o, 1'b0);
        chk({tag, "_valid"}, valid_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clk_g) start_i = 1'b1;
        @(negedge clk_g) start_i = 1'b0;
    endtask

    task automatic wait_round(input logic [3:0] r, output bit hit);
        hit = 1'b0;
        for (int n = 0; n < 500 && !hit; n++) begin
            if (ks_round_count_o == r && busy_o) hit = 1'b1;
            else @(negedge clk_g);
        end
    endtask

    task automatic run_expansion(input bit inject, input string tag);
        bit seen = 1'b0;
        bit pulsed = 1'b0;
        int base_done = done_cnt;
        int base_log = rlog.size();
        int seq_err = 0;
        pulse_start();
        for (int n = 0; n < 3000 && !seen; n++) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (inject && !pulsed && busy_o && ks_round_count_o == 4'd5) begin
                    start_i = 1'b1;
                    pulsed  = 1'b1;
                end
                @(negedge clk_g);
                start_i = 1'b0;
            end
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
        chk({tag, "_valid_at_done"}, valid_o, 1'b1);
        chk({tag, "_busy_at_done"}, busy_o, 1'b0);
        chk({tag, "_ks_en_at_done"}, ks_en_o, 1'b0);
        @(negedge clk_g);
        chk({tag, "_done_one_cycle"}, done_o, 1'b0);
        repeat (4) @(negedge clk_g);
        chk({tag, "_done_count"}, 128'(done_cnt - base_done), 128'd1);
        chk({tag, "_round_log_len"}, 128'(rlog.size() - base_log), 128'd15);
        for (int i = base_log; i < rlog.size(); i++) begin
            if (rlog[i] != 4'(i - base_log)) seq_err++;
        end
        chk({tag, "_round_sequence"}, 128'(seq_err), 128'd0);
    endtask

    task automatic apply_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_g) rd_idx_i = tbl[i].idx;
            @(negedge clk_g);
            chk($sformatf("%s_rd_key_%0d", tag, tbl[i].idx), rd_key_o, tbl[i].key);
            chk($sformatf("%s_rd_valid_%0d", tag, tbl[i].idx), rd_valid_o, tbl[i].vld);
        end
    endtask

    initial begin
        bit hit;
        int n;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        rd_idx_i = 4'd0;
        build_model();
        for (int i = 0; i < 16; i++) begin
            int j = (i * 7) % 16;
            tbl[i].idx = 4'(j);
            tbl[i].key = (j < 15) ? rk[j] : 128'd0;
            tbl[i].vld = (j < 15);
        end

        // Reset state
        repeat (3) @(negedge clk_g);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Full expansion with a start pulse injected at round 5
        run_expansion(1'b1, "run1");
        @(negedge clk_g) rd_idx_i = 4'd0;
        @(negedge clk_g);
        chk("fips_store0", rd_key_o, 128'h000102030405060708090a0b0c0d0e0f);
        @(negedge clk_g) rd_idx_i = 4'd14;
        @(negedge clk_g);
        chk("fips_store14", rd_key_o, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        apply_table("sweep1");

        // Schedule stalls at round 3
        stall_round = 4'd3;
        pulse_start();
        wait_round(4'd3, hit);
        chk("tmo_reach_round3", hit, 1'b1);
        n = 0;
        while (!err_o && n < 200) begin
            @(negedge clk_g);
            n++;
        end
        chk("tmo_cycles", 128'(n), 128'd64);
        chk("tmo_err", err_o, 1'b1);
        chk("tmo_busy", busy_o, 1'b0);
        chk("tmo_ks_en", ks_en_o, 1'b0);
        chk("tmo_valid", valid_o, 1'b0);
        repeat (3) @(negedge clk_g);
        chk("tmo_err_sticky", err_o, 1'b1);
        stall_round = 4'd15;
        pulse_start();
        chk("restart_clears_err", err_o, 1'b0);
        chk("restart_busy", busy_o, 1'b1);

        // Flush at round 7
        wait_round(4'd7, hit);
        chk("flush_reach_round7", hit, 1'b1);
        flush_i = 1'b1;
        @(negedge clk_g) flush_i = 1'b0;
        chk("flush_ks_en", ks_en_o, 1'b0);
        chk("flush_busy", busy_o, 1'b0);
        chk("flush_valid", valid_o, 1'b0);
        chk("flush_err", err_o, 1'b0);
        @(negedge clk_g) begin start_i = 1'b1; flush_i = 1'b1; end
        @(negedge clk_g) begin start_i = 1'b0; flush_i = 1'b0; end
        chk("start_flush_busy", busy_o, 1'b0);
        chk("start_flush_ks_en", ks_en_o, 1'b0);

        // Asynchronous reset at round 10
        pulse_start();
        wait_round(4'd10, hit);
        chk("rst_reach_round10", hit, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk_g) rst_n = 1'b1;

        // Rerun must rebuild an identical store
        run_expansion(1'b0, "run2");
        apply_table("sweep2");

        // Flush while idle with valid keys
        @(negedge clk_g) begin rd_idx_i = 4'd2; flush_i = 1'b1; end
        @(negedge clk_g) flush_i = 1'b0;
        chk("idle_flush_valid", valid_o, 1'b0);
        @(negedge clk_g);
        chk("idle_flush_rd_valid", rd_valid_o, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
